logic_32_bit_serial: RTL and testbench

- Multi-cycle, slice-serial 32-bit bitwise logic unit.
- Computes BUF, INV, AND, OR or NOR of latched operands, SLICE_WIDTH bits per clock, under a START/BUSY/DONE handshake.
- Consumer-side companion to the single-cycle 32-bit gate arrays. Used where the datapath steps a logic operation over several cycles instead of spending a full-width gate array.

---
 rtl/logic_32_bit_serial.sv | 134 +++++++++++++
 tb/tb_logic_32_bit_serial.sv | 122 ++++++++++++
 2 files changed

// File: rtl/logic_32_bit_serial.sv
// Slice-serial bitwise logic unit: BUF/INV/AND/OR/NOR over DATA_WIDTH bits, SLICE_WIDTH per cycle.
// Define LOGIC_SERIAL_XOR_EN to make opcode 101 a legal XOR.

module logic_serial_lane (
  input  logic [2:0] opr,
  input  logic       a,
  input  logic       b,
  output logic       y
);
  always_comb begin
    y = 1'b0;
    case (opr)
      3'd0: y = a;
      3'd1: y = ~a;
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = ~(a | b);
`ifdef LOGIC_SERIAL_XOR_EN
      3'd5: y = a ^ b;
`endif
      default: y = 1'b0;
    endcase
  end
endmodule

module logic_32_bit_serial #(
  parameter int DATA_WIDTH  = 32,
  parameter int SLICE_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [2:0]            OPR,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic [DATA_WIDTH-1:0] Y,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);
  localparam int N  = DATA_WIDTH / SLICE_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef struct packed {
    logic [2:0]            opr;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } req_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE_ST} state_t;

  state_t                  state_q, state_d;
  req_t                    req_q;
  logic [CW-1:0]           cnt_q;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [SLICE_WIDTH-1:0]  a_sl, b_sl, y_sl;
  logic                    last_slice, illegal;
  int unsigned             base;

  assign last_slice = (cnt_q == CW'(N - 1));

`ifdef LOGIC_SERIAL_XOR_EN
  assign illegal = (req_q.opr > 3'd5);
`else
  assign illegal = (req_q.opr > 3'd4);
`endif

  // slice select and merge back into the accumulator
  always_comb begin
    base  = 32'(cnt_q) * SLICE_WIDTH;
    a_sl  = req_q.a[base +: SLICE_WIDTH];
    b_sl  = req_q.b[base +: SLICE_WIDTH];
    acc_d = acc_q;
    acc_d[base +: SLICE_WIDTH] = y_sl;
  end

  for (genvar i = 0; i < SLICE_WIDTH; i++) begin : g_lane
    logic_serial_lane u_lane (
      .opr (req_q.opr),
      .a   (a_sl[i]),
      .b   (b_sl[i]),
      .y   (y_sl[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE_ST;
      DONE_ST: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state_q == RUN);
    DONE = (state_q == DONE_ST);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      req_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      Y     <= '0;
      ERR   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (START) begin
          req_q <= '{opr: OPR, a: A, b: B};
          cnt_q <= '0;
          acc_q <= '0;
        end
        RUN: begin
          acc_q <= acc_d;
          if (last_slice) begin
            cnt_q <= '0;
            Y     <= illegal ? '0 : acc_d;
            ERR   <= illegal;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_logic_32_bit_serial.sv
// Directed bench for logic_32_bit_serial: handshake latency, opcodes, illegal ops, reset abort.

module tb_logic_32_bit_serial;
  logic        CLK = 1'b0;
  logic        RST, START;
  logic [2:0]  OPR;
  logic [31:0] A, B, Y;
  logic        BUSY, DONE, ERR;
  int          total = 0;
  int          bad   = 0;
  int          lat, busy_n, done_n;

  logic_32_bit_serial dut (
    .CLK(CLK), .RST(RST), .START(START), .OPR(OPR), .A(A), .B(B),
    .Y(Y), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // accept one op, then wait (bounded) for DONE; checks latency, BUSY span, result, and DONE drop
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_y, input logic exp_err);
    START = 1'b1; OPR = op; A = a; B = b;
    tick();
    START = 1'b0;
    lat = 0; busy_n = 0;
    while (!DONE && lat < 20) begin
      if (BUSY) busy_n++;
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_busy"}, busy_n, 4);
    chk({tag, "_y"}, Y, exp_y);
    chk({tag, "_err"}, {31'd0, ERR}, {31'd0, exp_err});
    tick();
    chk({tag, "_done_drop"}, {30'd0, DONE, BUSY}, 32'd0);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; OPR = 3'd0; A = '0; B = '0;
    tick(); tick();
    RST = 1'b0;
    chk("rst_y", Y, 32'h0);
    chk("rst_flags", {29'd0, BUSY, DONE, ERR}, 32'd0);

    run_op("and", 3'd2, 32'hF0F01234, 32'hFF00FF0F, 32'hF0001204, 1'b0);
    run_op("inv", 3'd1, 32'h12345678, 32'h0, 32'hEDCBA987, 1'b0);

    // NOR with Y-hold checks while it runs
    START = 1'b1; OPR = 3'd4; A = 32'h0; B = 32'h0000FFFF;
    tick();
    START = 1'b0;
    chk("nor_hold0", Y, 32'hEDCBA987);
    tick(); tick(); tick();
    chk("nor_hold3", Y, 32'hEDCBA987);
    tick();
    chk("nor_done", {31'd0, DONE}, 32'd1);
    chk("nor_y", Y, 32'hFFFF0000);
    tick();

    run_op("ill7", 3'd7, 32'h12345678, 32'h9ABCDEF0, 32'h0, 1'b1);
    run_op("or", 3'd3, 32'h0000000F, 32'h000000F0, 32'h000000FF, 1'b0);

    // operand changes and a START pulse mid-run must not disturb the latched op
    START = 1'b1; OPR = 3'd3; A = 32'h12340000; B = 32'h00005678;
    tick();
    START = 1'b0; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; OPR = 3'd1;
    tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    done_n = 0;
    for (int i = 0; i < 10; i++) begin
      if (DONE) begin
        done_n++;
        chk("iso_y", Y, 32'h12345678);
      end
      tick();
    end
    chk("iso_done_cnt", done_n, 1);

    // reset after two RUN cycles aborts without DONE
    START = 1'b1; OPR = 3'd2; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
    tick();
    START = 1'b0;
    tick(); tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_flags", {29'd0, BUSY, DONE, ERR}, 32'd0);
    chk("abort_y", Y, 32'h0);
    done_n = 0;
    for (int i = 0; i < 6; i++) begin
      if (DONE) done_n++;
      tick();
    end
    chk("abort_no_done", done_n, 0);
    run_op("buf", 3'd0, 32'hCAFEBABE, 32'h0, 32'hCAFEBABE, 1'b0);

`ifdef LOGIC_SERIAL_XOR_EN
    run_op("op5", 3'd5, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0);
`else
    run_op("op5", 3'd5, 32'hAAAA5555, 32'hFFFF0000, 32'h00000000, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
